led_matrix_scan_driver: RTL and testbench
=========================================

// Module: led_matrix_scan_driver
// PURPOSE
// - Downstream of the game-logic stage: consumes the 8x8 checked board (checkedMatrix, 8 rows x 8 bits) plus gameState.
// - Time-multiplexes the board onto an 8x8 LED matrix, one row at a time, with a blanking gap between rows.
// - Double-buffers the board so a row update mid-frame never tears the image.
// PARAMETERS
// - DWELL_CYCLES   4   clk cycles each row is driven; must be >= 1.
// - BLANK_CYCLES   1   all-off clk cycles before each row; 0 = no blanking.
// - BLINK_FRAMES   8   frames per on/off half-period in game-over blink; only used when GAMEOVER_BLINK_EN is defined.
// PORTS
// - clk          in   1       system clock.
// - reset        in   1       synchronous, active-high reset.
// - frame_in     in   [7:0] x [0:7]  board rows; frame_in[r][c] = 1 lights row r, column c; row 0 is the top row.
// - game_state   in   1       1 = playing, 0 = game over.
// - row_sel      out  8       one-hot active-high row enable; bit r = row r.
// - col_data     out  8       column data for the enabled row; bit c = column c.
// - frame_start  out  1       one-cycle pulse in the LATCH cycle, when a new snapshot is taken.
// BEHAVIOUR
// - All outputs are registered.
// - Reset values: row_sel=0, col_data=0, frame_start=0, shadow buffer all 0, row index=0, counters=0, FSM=LATCH.
// - FSM states: LATCH -> BLANK -> DRIVE -> (BLANK of the next row | LATCH after row 7).
// - LATCH: 1 cycle.
//   - shadow[0:7] <= frame_in; row index <= 0; frame_start=1.
//   - row_sel=0, col_data=0.
// - BLANK: BLANK_CYCLES cycles; row_sel=0, col_data=0.
//   - State is skipped entirely when BLANK_CYCLES=0 (DRIVE follows LATCH/DRIVE directly).
// - DRIVE: DWELL_CYCLES cycles; row_sel = 8'b1 << row, col_data = shadow[row].
//   - At the end of DRIVE: if row==7 go to LATCH, else row+1 and go to BLANK.
// - Frame length = 1 + 8*(BLANK_CYCLES+DWELL_CYCLES) cycles; 41 at defaults.
// - Outputs reflect the current state in the same cycle (Moore style).
// - frame_in is sampled only in LATCH; changes at any other time do not affect the current frame.
// - row_sel is never multi-hot and is never nonzero while col_data belongs to a different row.
// - Counter width: $clog2(max(DWELL_CYCLES, BLANK_CYCLES)+1); the counter resets to 0 on every state entry.
// - Reset asserted mid-frame: on the next edge all outputs go to 0, the shadow is cleared and the FSM is in LATCH.
//   - The first cycle after reset release is LATCH.
// CONFIGURATION
// - Macro GAMEOVER_BLINK_EN defined:
//   - game_state is sampled in each LATCH cycle.
//   - While it samples 0, a frame counter increments once per LATCH.
//   - The display phase toggles every BLINK_FRAMES frames; the first game-over frame is in the "on" phase.
//   - In the "off" phase, col_data is forced to 0 during DRIVE; row_sel still scans normally.
//   - Sampling game_state=1 in LATCH clears the frame counter and sets the phase to on.
// - Macro undefined: game_state is ignored (port kept, unused); the display is never blanked by game state.
// TESTING
// - Defaults; reset 3 cycles then release; frame_in rows = 8'h01,02,04,08,10,20,40,80
//   -> frame_start at cycle 0; row_sel=01/col_data=01 on cycles 2-5; row_sel=80/col_data=80 on cycles 37-40; frame_start again at cycle 41.
// - Change frame_in[5] from 8'h20 to 8'hFF at cycle 10
//   -> row 5 still shows 8'h20 in that frame; shows 8'hFF in the next frame (cycles 68-71 after reset).
// - BLANK_CYCLES=0, DWELL_CYCLES=1
//   -> frame is 9 cycles; row_sel walks 01,02,..,80 on consecutive cycles after each LATCH.
// - Assert reset during DRIVE of row 3
//   -> next cycle row_sel=0, col_data=0; after release the first cycle is LATCH with frame_start=1 and row 0 is driven next.
// - GAMEOVER_BLINK_EN, BLINK_FRAMES=2, game_state=0, all rows 8'hFF
//   -> frames 0-1 col_data=FF in DRIVE; frames 2-3 col_data=00 with row_sel scanning; frames 4-5 FF.
//   -> game_state=1 restores FF from the next frame.
// - Macro undefined, same stimulus -> col_data=FF in every DRIVE cycle of every frame.
// - Continuous check throughout: $onehot0(row_sel); col_data==0 whenever row_sel==0.

Source files
------------

// File: rtl/led_matrix_scan_driver_if.sv
// Board-to-LED-matrix bundle: board rows and game state in, row/column drive out.
// master = board source / observer side, slave = scan driver side.
interface led_matrix_scan_driver_if;
  logic [0:7][7:0] frame_in;
  logic            game_state;
  logic [7:0]      row_sel;
  logic [7:0]      col_data;
  logic            frame_start;

  modport master (
    output frame_in,
    output game_state,
    input  row_sel,
    input  col_data,
    input  frame_start
  );

  modport slave (
    input  frame_in,
    input  game_state,
    output row_sel,
    output col_data,
    output frame_start
  );
endinterface

// File: rtl/led_matrix_scan_driver.sv
// Row-scanned 8x8 LED driver with a snapshot buffer and blanking gaps.
// Ports: clk, reset (sync, active high), bus (slave): frame_in, game_state
// in; row_sel, col_data, frame_start out. Macro GAMEOVER_BLINK_EN adds
// game-over blinking every BLINK_FRAMES frames.
module led_matrix_scan_driver #(
  parameter int DWELL_CYCLES = 4,
  parameter int BLANK_CYCLES = 1,
  parameter int BLINK_FRAMES = 8
) (
  input logic clk,
  input logic reset,
  led_matrix_scan_driver_if.slave bus
);

  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ?
                        DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [1:0] S_LATCH = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;

  // With no blanking the gap state collapses straight into DRIVE.
  localparam logic [1:0] S_GAP =
    (BLANK_CYCLES > 0) ? S_BLANK : S_DRIVE;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST =
    CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  logic [1:0]      state;
  logic [1:0]      state_nx;
  logic            adv;
  logic [CW-1:0]   cnt;
  logic [2:0]      row;
  logic [0:7][7:0] shadow;
  logic            show;
  logic [7:0]      row_sel_q;
  logic [7:0]      col_data_q;
  logic            frame_start_q;

  assign bus.row_sel     = row_sel_q;
  assign bus.col_data    = col_data_q;
  assign bus.frame_start = frame_start_q;

  // adv marks the last cycle of the current state; DRIVE->DRIVE between
  // rows (no blanking) is still a fresh entry, so the counter restarts.
  always_comb begin
    adv      = 1'b0;
    state_nx = state;
    unique case (state)
      S_LATCH: begin
        adv      = 1'b1;
        state_nx = S_GAP;
      end
      S_BLANK: begin
        adv = (cnt == BLANK_LAST);
        if (adv) state_nx = S_DRIVE;
      end
      S_DRIVE: begin
        adv = (cnt == DWELL_LAST);
        if (adv) state_nx = (row == 3'd7) ? S_LATCH : S_GAP;
      end
      default: begin
        adv      = 1'b1;
        state_nx = S_LATCH;
      end
    endcase
  end

  // Outputs are registered from the state being processed at each edge,
  // so they change on the same edges as the visible scan sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_LATCH;
      cnt           <= '0;
      row           <= 3'd0;
      shadow        <= '0;
      row_sel_q     <= 8'h00;
      col_data_q    <= 8'h00;
      frame_start_q <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= adv ? '0 : cnt + 1'b1;
      frame_start_q <= (state == S_LATCH);
      row_sel_q     <= 8'h00;
      col_data_q    <= 8'h00;
      unique case (1'b1)
        (state == S_LATCH): begin
          shadow <= bus.frame_in;
          row    <= 3'd0;
        end
        (state == S_DRIVE): begin
          row_sel_q  <= 8'b1 << row;
          col_data_q <= show ? shadow[row] : 8'h00;
          if (adv && row != 3'd7) row <= row + 3'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef GAMEOVER_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  logic [BW-1:0] bcnt;
  logic          phase_on;

  // bcnt counts game-over frames already shown in the current phase;
  // the phase flips when a frame would exceed BLINK_FRAMES.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt     <= '0;
      phase_on <= 1'b1;
    end else if (state == S_LATCH) begin
      if (bus.game_state) begin
        bcnt     <= '0;
        phase_on <= 1'b1;
      end else if (bcnt == BW'(BLINK_FRAMES)) begin
        bcnt     <= BW'(1);
        phase_on <= ~phase_on;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  assign show = phase_on;
`else
  localparam int unused_blink = BLINK_FRAMES;
  logic unused_gs;
  assign unused_gs = bus.game_state;
  assign show      = 1'b1;
`endif

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Scoreboard bench: default DUT plus a no-blank, single-dwell DUT.
// Stimulus pushes expected outputs; negedge monitor pops and compares.
module tb_led_matrix_scan_driver;

  typedef struct packed {
    logic [7:0] rs;
    logic [7:0] cd;
    logic       fs;
  } exp_t;

  localparam int BF  = 2;
  localparam int FL1 = 41;
  localparam int FL2 = 9;

  logic clk = 1'b0;
  logic reset;
  logic rst2;

  int checks   = 0;
  int failures = 0;
  bit done2    = 1'b0;

  exp_t q1[$];
  exp_t q2[$];

  led_matrix_scan_driver_if m_if ();
  led_matrix_scan_driver_if s_if ();

  led_matrix_scan_driver #(
    .DWELL_CYCLES(4),
    .BLANK_CYCLES(1),
    .BLINK_FRAMES(BF)
  ) dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (m_if)
  );

  led_matrix_scan_driver #(
    .DWELL_CYCLES(1),
    .BLANK_CYCLES(0),
    .BLINK_FRAMES(8)
  ) dut2 (
    .clk  (clk),
    .reset(rst2),
    .bus  (s_if)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(int t, int b, int d,
                                 logic [0:7][7:0] sh, logic on);
    exp_t e;
    int r;
    int p;
    e = '0;
    if (t == 0) begin
      e.fs = 1'b1;
    end else begin
      r = (t - 1) / (b + d);
      p = (t - 1) % (b + d);
      if (p >= b) begin
        e.rs = 8'(1 << r);
        e.cd = on ? sh[r] : 8'h00;
      end
    end
    return e;
  endfunction

  task automatic check(string nm, exp_t e,
                       logic [7:0] rs, logic [7:0] cd, logic fs);
    checks++;
    if ({rs, cd, fs} !== e) begin
      failures++;
      $display("FAIL %s: got rs=%h cd=%h fs=%b want rs=%h cd=%h fs=%b",
               nm, rs, cd, fs, e.rs, e.cd, e.fs);
    end
    checks++;
    if (!$onehot0(rs) || (rs == 8'h00 && cd != 8'h00)) begin
      failures++;
      $display("FAIL %s_inv: got rs=%h cd=%h want onehot0, cd=0 when idle",
               nm, rs, cd);
    end
  endtask

  always @(negedge clk) begin
    if (q1.size() > 0)
      check("dut1", q1.pop_front(),
            m_if.row_sel, m_if.col_data, m_if.frame_start);
    if (q2.size() > 0)
      check("dut2", q2.pop_front(),
            s_if.row_sel, s_if.col_data, s_if.frame_start);
  end

  int              t1 = 0;
  logic [0:7][7:0] sh1 = '0;
  logic            on1 = 1'b1;
  int              go_frames = 0;

  task automatic step1();
    @(posedge clk);
    #1;
    if (reset) begin
      q1.push_back('0);
      t1        = 0;
      sh1       = '0;
      on1       = 1'b1;
      go_frames = 0;
    end else begin
      if (t1 == 0) begin
        sh1 = m_if.frame_in;
`ifdef GAMEOVER_BLINK_EN
        if (m_if.game_state) begin
          go_frames = 0;
          on1       = 1'b1;
        end else begin
          on1 = ((go_frames / BF) % 2) == 0;
          go_frames++;
        end
`else
        on1 = 1'b1;
`endif
      end
      q1.push_back(model(t1, 1, 4, sh1, on1));
      t1 = (t1 + 1) % FL1;
    end
  endtask

  int              t2 = 0;
  logic [0:7][7:0] sh2 = '0;

  task automatic step2();
    @(posedge clk);
    #1;
    if (rst2) begin
      q2.push_back('0);
      t2  = 0;
      sh2 = '0;
    end else begin
      if (t2 == 0) sh2 = s_if.frame_in;
      q2.push_back(model(t2, 0, 1, sh2, 1'b1));
      t2 = (t2 + 1) % FL2;
    end
  endtask

  initial begin
    rst2            = 1'b1;
    s_if.game_state = 1'b0;
    for (int r = 0; r < 8; r++) s_if.frame_in[r] = 8'(8'hA0 + r);
    repeat (2) step2();
    rst2 = 1'b0;
    for (int k = 0; k < 3 * FL2; k++) step2();
    done2 = 1'b1;
  end

  initial begin
    reset           = 1'b1;
    m_if.game_state = 1'b1;
    for (int r = 0; r < 8; r++) m_if.frame_in[r] = 8'(1 << r);
    repeat (3) step1();
    reset = 1'b0;

    for (int k = 0; k < 2 * FL1; k++) begin
      step1();
      if (k == 10) m_if.frame_in[5] = 8'hFF;
    end

    for (int k = 0; k < 19; k++) step1();
    reset = 1'b1;
    repeat (2) step1();
    reset = 1'b0;
    for (int k = 0; k < FL1; k++) step1();

    for (int r = 0; r < 8; r++) m_if.frame_in[r] = 8'hFF;
    m_if.game_state = 1'b0;
    for (int k = 0; k < 6 * FL1; k++) step1();
    m_if.game_state = 1'b1;
    for (int k = 0; k < 2 * FL1; k++) step1();

    for (int k = 0; k < 200 && !done2; k++) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (!done2 || q1.size() != 0 || q2.size() != 0) begin
      failures++;
      $display("FAIL drain: got done2=%0b q1=%0d q2=%0d want 1 0 0",
               done2, q1.size(), q2.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
